song_timer_gen: RTL
===================

Name: song_timer_gen

Overview:
Parametrised song-elapsed-time tracker for the central FSM, with the graphics and display blocks as consumers. Divides clk down to a configurable sub-second tick rate. Tracks elapsed ticks and seconds and supports pause/hold, seek and a song-length limit with a one-shot time-up event. Also provides remaining time and tick/second strobes for beat-synchronous graphics.

Parameters:
CLK_HZ, 27000000, clk frequency in Hz
TICK_HZ, 10, sub-second ticks per second; CLK_HZ must be an exact multiple of TICK_HZ; TICK_HZ >= 2
SEC_W, 10, width of all seconds-valued ports
FRAC_W, 4, width of tick_frac; 2^FRAC_W >= TICK_HZ

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
start_song  in  1  pulse from FSM; clear and start counting
pause_song  in  1  level from FSM; hold counting while high
song_done  in  1  level from memory; hold counting while high
seek_valid  in  1  pulse; load seek_sec
seek_sec  in  SEC_W  seek target in seconds
limit_sec  in  SEC_W  song length in seconds; 0 = no limit
seconds_elap  out  SEC_W  whole seconds elapsed
tick_frac  out  FRAC_W  ticks within current second, 0..TICK_HZ-1
remaining_sec  out  SEC_W  limit_sec - seconds_elap, saturating at 0; 0 when limit_sec=0
tick_pulse  out  1  one-cycle strobe on each tick advance
sec_pulse  out  1  one-cycle strobe on each seconds_elap increment
running  out  1  high when state=RUN
time_up  out  1  one-cycle pulse on entry to EXPIRED via counting

Behaviour:
- Clock and reset: all state is on posedge clk. Reset is synchronous and active-high. Reset forces state=IDLE and clears the prescaler, tick_frac, seconds_elap and every pulse output to 0.
- Prescaler: DIV = CLK_HZ/TICK_HZ. The prescaler counts 0..DIV-1 and wraps to 0.
- Count-enable cycle: state=RUN and pause_song=0 and song_done=0.
- Tick timing: a tick occurs on a count-enable cycle with prescaler==DIV-1. Exactly DIV enabled cycles separate successive ticks; the divider has no off-by-one.
- On a tick: tick_pulse=1 the next cycle, and tick_frac increments. At TICK_HZ-1, tick_frac wraps to 0, seconds_elap increments and sec_pulse=1 (same cycle as tick_pulse).
- seconds_elap saturates at 2^SEC_W-1. At saturation, tick_frac stays at TICK_HZ-1 and no further sec_pulse is issued.
- States:
  - IDLE: counters frozen.
  - RUN: counting per the count-enable rule.
  - HOLD: entered from RUN when pause_song or song_done is high. Returns to RUN when both are low. The prescaler value is retained, so a partial tick resumes exactly.
  - EXPIRED: counters frozen at the limit.
- Limit: when limit_sec!=0 and a second increment makes seconds_elap==limit_sec, go to EXPIRED with tick_frac=0 and time_up=1 for one cycle. Only start_song, seek or reset leave EXPIRED.
- A limit_sec change while running takes effect on the next comparison. If seconds_elap already exceeds the new limit, the block goes to EXPIRED the next cycle with no time_up pulse.
- start_song in any state: prescaler, tick_frac and seconds_elap cleared; state=RUN next cycle; no pulses that cycle.
- seek_valid, ignored in IDLE:
  - Load seconds_elap = min(seek_sec, limit_sec) when limit_sec!=0, else seek_sec.
  - tick_frac=0, prescaler=0.
  - If the loaded value equals a nonzero limit: state=EXPIRED with no time_up pulse.
  - Otherwise RUN/HOLD keep their state and EXPIRED goes to HOLD.
- Priority in one cycle: reset > start_song > seek_valid > limit/expiry > counting. A tick coinciding with start or seek is discarded.
- Timing: remaining_sec and running are registered and reflect state and counters with one cycle latency from the registers they depend on.

Test Plan:
- CLK_HZ=20, TICK_HZ=4 (DIV=5), limit=0:
  - Pulse start_song → running=1.
  - tick_pulse every 5 cycles.
  - After 20 enabled cycles: seconds_elap=1, tick_frac=0, sec_pulse coincides with the 4th tick_pulse.
- Pause then resume: assert pause_song at prescaler=3 for 7 cycles → counters frozen and running=0. After deassertion, the next tick occurs 2 enabled cycles later. Repeat with song_done.
- Limit: limit_sec=2, start → time_up single pulse at 40 enabled cycles, seconds_elap=2, remaining_sec=0, state EXPIRED. A further 100 cycles produce no change.
- Seek:
  - seek_sec=1 while in EXPIRED with limit 2 → seconds_elap=1, HOLD. With pause low → RUN, expires again after 20 cycles.
  - seek_sec=5 with limit 2 → seconds_elap=2, EXPIRED, no time_up.
- Simultaneity: start_song and seek_valid in the same cycle as a tick → all counters 0, no tick_pulse. Reset mid-run → all outputs 0 and IDLE, ignoring ticks until start_song.
- Saturation: SEC_W=2, limit=0, run 5 s → seconds_elap stays at 3, tick_frac=3, no sec_pulse after the 3rd.

Source files
------------

// File: rtl/song_timer_gen.sv
// Song elapsed-time tracker: divides clk to a sub-second tick, counts ticks and
// seconds with pause/hold, seek, a song-length limit and a one-shot time-up event.
module song_timer_gen #(
  parameter int CLK_HZ  = 27000000,
  parameter int TICK_HZ = 10,
  parameter int SEC_W   = 10,
  parameter int FRAC_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start_song,
  input  logic              i_pause_song,
  input  logic              i_song_done,
  input  logic              i_seek_valid,
  input  logic [SEC_W-1:0]  i_seek_sec,
  input  logic [SEC_W-1:0]  i_limit_sec,
  output logic [SEC_W-1:0]  o_seconds_elap,
  output logic [FRAC_W-1:0] o_tick_frac,
  output logic [SEC_W-1:0]  o_remaining_sec,
  output logic              o_tick_pulse,
  output logic              o_sec_pulse,
  output logic              o_running,
  output logic              o_time_up
);

  localparam int DIV  = CLK_HZ / TICK_HZ;
  localparam int PS_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PS_W-1:0]   PS_LAST   = PS_W'(DIV - 1);
  localparam logic [FRAC_W-1:0] FRAC_LAST = FRAC_W'(TICK_HZ - 1);
  localparam logic [SEC_W-1:0]  SEC_MAX   = '1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_HOLD    = 2'd2;
  localparam logic [1:0] S_EXPIRED = 2'd3;

  logic [1:0]        r_state;
  logic [PS_W-1:0]   r_presc;
  logic [FRAC_W-1:0] r_frac;
  logic [SEC_W-1:0]  r_sec;
  logic [SEC_W-1:0]  r_rem;
  logic              r_tick_pulse;
  logic              r_sec_pulse;
  logic              r_running;
  logic              r_time_up;

  logic              w_limit_on;
  logic              w_over_limit;
  logic              w_halt;
  logic [SEC_W-1:0]  w_seek_val;
  logic [SEC_W-1:0]  w_sec_next;

  assign w_limit_on   = (i_limit_sec != '0);
  assign w_over_limit = w_limit_on && (r_sec > i_limit_sec);
  assign w_halt       = i_pause_song || i_song_done;
  assign w_seek_val   = (w_limit_on && (i_seek_sec > i_limit_sec)) ? i_limit_sec : i_seek_sec;
  assign w_sec_next   = r_sec + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_presc      <= '0;
      r_frac       <= '0;
      r_sec        <= '0;
      r_rem        <= '0;
      r_tick_pulse <= 1'b0;
      r_sec_pulse  <= 1'b0;
      r_running    <= 1'b0;
      r_time_up    <= 1'b0;
    end else begin
      // NOTE: strobes default low every cycle and are only raised below, so each is one cycle wide.
      r_tick_pulse <= 1'b0;
      r_sec_pulse  <= 1'b0;
      r_time_up    <= 1'b0;
      r_running    <= (r_state == S_RUN);
      r_rem        <= (w_limit_on && (i_limit_sec > r_sec)) ? (i_limit_sec - r_sec) : '0;

      if (i_start_song) begin
        r_state <= S_RUN;
        r_presc <= '0;
        r_frac  <= '0;
        r_sec   <= '0;
      end else if (i_seek_valid && (r_state != S_IDLE)) begin
        r_sec   <= w_seek_val;
        r_frac  <= '0;
        r_presc <= '0;
        if (w_limit_on && (w_seek_val == i_limit_sec)) begin
          r_state <= S_EXPIRED;
        end else if (r_state == S_EXPIRED) begin
          r_state <= S_HOLD;
        end
      end else if (((r_state == S_RUN) || (r_state == S_HOLD)) && w_over_limit) begin
        r_state <= S_EXPIRED;
      end else begin
        case (r_state)
          S_RUN: begin
            if (w_halt) begin
              r_state <= S_HOLD;
            end else if (r_presc != PS_LAST) begin
              r_presc <= r_presc + 1'b1;
            end else begin
              r_presc <= '0;
              if (r_frac != FRAC_LAST) begin
                r_frac       <= r_frac + 1'b1;
                r_tick_pulse <= 1'b1;
              end else if (r_sec != SEC_MAX) begin
                r_frac       <= '0;
                r_sec        <= w_sec_next;
                r_tick_pulse <= 1'b1;
                r_sec_pulse  <= 1'b1;
                if (w_limit_on && (w_sec_next == i_limit_sec)) begin
                  r_state   <= S_EXPIRED;
                  r_time_up <= 1'b1;
                end
              end
              // Saturated: seconds and tick_frac stay pinned at their maxima.
            end
          end
          S_HOLD: begin
            if (!w_halt) r_state <= S_RUN;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_seconds_elap  = r_sec;
  assign o_tick_frac     = r_frac;
  assign o_remaining_sec = r_rem;
  assign o_tick_pulse    = r_tick_pulse;
  assign o_sec_pulse     = r_sec_pulse;
  assign o_running       = r_running;
  assign o_time_up       = r_time_up;

endmodule
